// File: rtl/rot_buffer_pkg.sv
// Shared types and address helpers for the sector-banked rotational frame buffer.
// A theta splits into sector (upper bits) and in-bank address (lower bits).
package rot_buffer_pkg;

    typedef enum logic [1:0] {
        WR_SET   = 2'd0,
        WR_WRITE = 2'd1,
        WR_CLEAR = 2'd2
    } write_mode_t;

    typedef enum logic {
        IDLE     = 1'b0,
        FLUSHING = 1'b1
    } buffer_state_t;

    function automatic int unsigned sector_of(input int unsigned theta, input int unsigned addr_bits);
        return theta >> addr_bits;
    endfunction

    function automatic int unsigned addr_of(input int unsigned theta, input int unsigned addr_bits);
        return theta & ((32'd1 << addr_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/rot_buffer_bank.sv
// Dual-port read-first block RAM with a 2-cycle registered output on each port.
// Port A has separate read and write-back addresses so a read-modify-write pipeline can issue every cycle.
module rot_buffer_bank #(
    parameter  int WIDTH = 69,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [AW-1:0]    a_raddr_in,
    input  logic [AW-1:0]    a_waddr_in,
    input  logic             a_we_in,
    input  logic [WIDTH-1:0] a_wdata_in,
    output logic [WIDTH-1:0] a_rdata_out,
    input  logic             b_en_in,
    input  logic [AW-1:0]    b_addr_in,
    input  logic             b_we_in,
    input  logic [WIDTH-1:0] b_wdata_in,
    output logic [WIDTH-1:0] b_rdata_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] a_stage_q;
    logic [WIDTH-1:0] b_stage_q;
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;
    logic             b_en_q;

    // Array storage is never reset; non-blocking reads give read-first behaviour.
    always_ff @(posedge clk_in) begin
        if (a_we_in) mem_q[a_waddr_in] <= a_wdata_in;
        if (b_we_in) mem_q[b_addr_in] <= b_wdata_in;
        a_stage_q <= mem_q[a_raddr_in];
        if (b_en_in) b_stage_q <= mem_q[b_addr_in];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            b_en_q    <= 1'b0;
        end else begin
            a_rdata_q <= a_stage_q;
            b_en_q    <= b_en_in;
            if (b_en_q) b_rdata_q <= b_stage_q;
        end
    end

    assign a_rdata_out = a_rdata_q;
    assign b_rdata_out = b_rdata_q;

endmodule

// File: rtl/rot_sector_buffer.sv
// Rotational frame buffer split into NUM_SECTORS banks: one column per blade per cycle on
// the read side, pipelined read-modify-write voxel updates and a bulk flush on the write side.
module rot_sector_buffer
    import rot_buffer_pkg::*;
#(
    parameter  int ROTATIONAL_RES    = 1024,
    parameter  int NUM_SECTORS       = 4,
    parameter  int DISPLAY_RADIUS    = 32,
    parameter  int DISPLAY_HEIGHT    = 64,
    parameter  int DATA_SIZE         = 1,
    localparam int RADIUS_BITS       = $clog2(DISPLAY_RADIUS),
    localparam int SECTOR_DEPTH      = ROTATIONAL_RES / NUM_SECTORS,
    localparam int VOXEL_WIDTH       = DISPLAY_HEIGHT * DATA_SIZE,
    localparam int COLUMN_DATA_WIDTH = VOXEL_WIDTH + RADIUS_BITS,
    localparam int TW                = $clog2(ROTATIONAL_RES),
    localparam int ZW                = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     flush_in,
    output logic                                     busy_out,
    input  logic                                     wr_valid_in,
    output logic                                     wr_ready_out,
    input  logic [1:0]                               wr_mode_in,
    input  logic [TW-1:0]                            wr_theta_in,
    input  logic [ZW-1:0]                            wr_z_in,
    input  logic [RADIUS_BITS-1:0]                   wr_radius_in,
    input  logic [DATA_SIZE-1:0]                     wr_data_in,
    input  logic                                     rd_valid_in,
    input  logic [TW-1:0]                            rd_theta_in,
    output logic                                     rd_valid_out,
    output logic [NUM_SECTORS-1:0][VOXEL_WIDTH-1:0]  columns_out,
    output logic [NUM_SECTORS-1:0][RADIUS_BITS-1:0]  radii_out
);

    localparam int AW = $clog2(SECTOR_DEPTH);
    localparam int SB = $clog2(NUM_SECTORS);
    localparam int CW = COLUMN_DATA_WIDTH;

    buffer_state_t          state_q, state_d;
    logic                   flush_pending_q, flush_pending_d;
    logic [AW-1:0]          flush_addr_q, flush_addr_d;
    logic                   alive_q;
    logic                   s1_valid_q, s2_valid_q, s3_valid_q;
    logic [TW-1:0]          s1_theta_q, s2_theta_q, s3_theta_q;
    logic [1:0]             s1_mode_q, s2_mode_q;
    logic [ZW-1:0]          s1_z_q, s2_z_q;
    logic [RADIUS_BITS-1:0] s1_radius_q, s2_radius_q;
    logic [DATA_SIZE-1:0]   s1_data_q, s2_data_q;
    logic [CW-1:0]          s3_col_q, s3_col_d;
    logic                   rd_v1_q, rd_v2_q;
    logic [SB-1:0]          rd_sec1_q, rd_sec1_d, rd_sec2_q, rd_sec2_d;

    logic                   accept, pipe_busy, hazard, flushing;
    logic [SB-1:0]          s2_sector, s3_sector, bank_sel;
    logic [AW-1:0]          wr_addr, rd_addr, a_waddr;
    logic [CW-1:0]          a_wdata, old_col;
    logic [NUM_SECTORS-1:0] a_we;
    logic [CW-1:0]          a_rdata [NUM_SECTORS];
    logic [CW-1:0]          b_rdata [NUM_SECTORS];

    assign flushing  = (state_q == FLUSHING);
    assign pipe_busy = s1_valid_q | s2_valid_q | s3_valid_q;
    assign hazard    = (s1_valid_q && s1_theta_q == wr_theta_in) ||
                       (s2_valid_q && s2_theta_q == wr_theta_in) ||
                       (s3_valid_q && s3_theta_q == wr_theta_in);
    // A same-cycle flush request takes priority over a write.
    assign wr_ready_out = alive_q && !flushing && !flush_pending_q && !flush_in && !hazard;
    assign accept       = wr_valid_in && wr_ready_out;
    assign busy_out     = flushing | flush_pending_q | pipe_busy;
    assign rd_valid_out = rd_v2_q;

    assign wr_addr   = AW'(addr_of(32'(wr_theta_in), AW));
    assign rd_addr   = AW'(addr_of(32'(rd_theta_in), AW));
    assign s2_sector = SB'(sector_of(32'(s2_theta_q), AW));
    assign s3_sector = SB'(sector_of(32'(s3_theta_q), AW));
    assign a_waddr   = flushing ? flush_addr_q : AW'(addr_of(32'(s3_theta_q), AW));
    assign a_wdata   = flushing ? '0 : s3_col_q;
    assign old_col   = a_rdata[s2_sector];

    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        flush_addr_d    = flush_addr_q;
        case (state_q)
            IDLE: begin
                if (flush_in || flush_pending_q) begin
                    if (!pipe_busy) begin
                        state_d         = FLUSHING;
                        flush_pending_d = 1'b0;
                        flush_addr_d    = '0;
                    end else begin
                        flush_pending_d = 1'b1;
                    end
                end
            end
            FLUSHING: begin
                flush_addr_d = flush_addr_q + 1'b1;
                if (flush_addr_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s3_col_d = old_col;
        case (write_mode_t'(s2_mode_q))
            WR_SET: begin
                s3_col_d[s2_z_q*DATA_SIZE +: DATA_SIZE] = old_col[s2_z_q*DATA_SIZE +: DATA_SIZE] | s2_data_q;
                s3_col_d[CW-1 -: RADIUS_BITS]           = s2_radius_q;
            end
            WR_WRITE: begin
                s3_col_d[s2_z_q*DATA_SIZE +: DATA_SIZE] = s2_data_q;
                s3_col_d[CW-1 -: RADIUS_BITS]           = s2_radius_q;
            end
            WR_CLEAR: s3_col_d[s2_z_q*DATA_SIZE +: DATA_SIZE] = '0;
            default:  s3_col_d = old_col;
        endcase
    end

    always_comb begin
        a_we = '0;
        for (int k = 0; k < NUM_SECTORS; k++) begin
            a_we[k] = flushing || (s3_valid_q && s3_sector == SB'(k));
        end
    end

    // Sector of the read is carried alongside the bank latency so blades rotate onto the right bank.
    assign rd_sec1_d = rd_valid_in ? SB'(sector_of(32'(rd_theta_in), AW)) : rd_sec1_q;
    assign rd_sec2_d = rd_v1_q ? rd_sec1_q : rd_sec2_q;

    always_comb begin
        bank_sel    = '0;
        columns_out = '0;
        radii_out   = '0;
        for (int k = 0; k < NUM_SECTORS; k++) begin
            bank_sel = SB'(rd_sec2_q + SB'(k));
            if (!flushing) begin
                columns_out[k] = b_rdata[bank_sel][VOXEL_WIDTH-1:0];
                radii_out[k]   = b_rdata[bank_sel][CW-1 -: RADIUS_BITS];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            flush_pending_q <= 1'b0;
            flush_addr_q    <= '0;
            alive_q         <= 1'b0;
            s1_valid_q      <= 1'b0;
            s2_valid_q      <= 1'b0;
            s3_valid_q      <= 1'b0;
            rd_v1_q         <= 1'b0;
            rd_v2_q         <= 1'b0;
            rd_sec1_q       <= '0;
            rd_sec2_q       <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            flush_addr_q    <= flush_addr_d;
            alive_q         <= 1'b1;
            s1_valid_q      <= accept;
            s2_valid_q      <= s1_valid_q;
            s3_valid_q      <= s2_valid_q;
            rd_v1_q         <= rd_valid_in;
            rd_v2_q         <= rd_v1_q;
            rd_sec1_q       <= rd_sec1_d;
            rd_sec2_q       <= rd_sec2_d;
        end
    end

    always_ff @(posedge clk_in) begin
        s1_theta_q  <= wr_theta_in;
        s1_mode_q   <= wr_mode_in;
        s1_z_q      <= wr_z_in;
        s1_radius_q <= wr_radius_in;
        s1_data_q   <= wr_data_in;
        s2_theta_q  <= s1_theta_q;
        s2_mode_q   <= s1_mode_q;
        s2_z_q      <= s1_z_q;
        s2_radius_q <= s1_radius_q;
        s2_data_q   <= s1_data_q;
        s3_theta_q  <= s2_theta_q;
        s3_col_q    <= s3_col_d;
    end

    for (genvar g = 0; g < NUM_SECTORS; g++) begin : g_bank
        rot_buffer_bank #(
            .WIDTH (CW),
            .DEPTH (SECTOR_DEPTH)
        ) u_bank (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .a_raddr_in  (wr_addr),
            .a_waddr_in  (a_waddr),
            .a_we_in     (a_we[g]),
            .a_wdata_in  (a_wdata),
            .a_rdata_out (a_rdata[g]),
            .b_en_in     (rd_valid_in),
            .b_addr_in   (rd_addr),
            .b_we_in     (1'b0),
            .b_wdata_in  ({CW{1'b0}}),
            .b_rdata_out (b_rdata[g])
        );
    end

endmodule
